// File: rtl/bloco_controle.sv
// Moore control FSM for blocoOperativo: initialisation, then N passes of the
// STEP_H/STEP_S/STEP_F loop, with a start/busy/done handshake and abort.
module bloco_controle #(
  parameter int unsigned ITER_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] n_iter,
  input  logic              abort,
  output logic              LX,
  output logic              LH,
  output logic              LS,
  output logic [1:0]        M0,
  output logic [1:0]        M1,
  output logic [1:0]        M2,
  output logic              H,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadX,
    StSettle,
    StStepH,
    StStepS,
    StStepF,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    LX      = 1'b0;
    LH      = 1'b0;
    LS      = 1'b0;
    M0      = 2'b00;
    M1      = 2'b00;
    M2      = 2'b00;
    H       = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          // A zero loop count still runs the loop once.
          cnt_d   = (n_iter == '0) ? ITER_W'(1) : n_iter;
          state_d = StLoadX;
        end
      end
      StLoadX: begin
        LX      = 1'b1;
        M1      = 2'b01;
        H       = 1'b1;
        state_d = StSettle;
      end
      StSettle: begin
        M1      = 2'b01;
        H       = 1'b1;
        state_d = StStepH;
      end
      StStepH: begin
        M1      = 2'b01;
        LH      = 1'b1;
        H       = 1'b1;
        state_d = StStepS;
      end
      StStepS: begin
        M0      = 2'b01;
        M1      = 2'b11;
        M2      = 2'b01;
        LS      = 1'b1;
        H       = 1'b1;
        state_d = StStepF;
      end
      StStepF: begin
        M0 = 2'b10;
        M1 = 2'b01;
        LH = 1'b1;
        H  = 1'b1;
        if (cnt_q > ITER_W'(1)) begin
          cnt_d   = cnt_q - ITER_W'(1);
          state_d = StStepH;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy = (state_q != StIdle) && (state_q != StDone);

    // Abort cancels without touching the loop counter.
    if (busy && abort) begin
      state_d = StIdle;
      cnt_d   = cnt_q;
    end
  end

endmodule
